// File: rtl/iob_req_slice.sv
// IOb request/response register slice: two-entry request skid buffer plus registered read response.
// Latency: request 1 cycle, read response 1 cycle. Backpressure: s_iob_ready_o drops only when the skid entry is full.
// Reads are held in the main entry while MAX_RD_OUTSTANDING reads are in flight, stalling everything behind them.
module iob_req_slice #(
    parameter int ADDR_WIDTH         = 32,
    parameter int DATA_WIDTH         = 32,
    parameter int STRB_WIDTH         = DATA_WIDTH / 8,
    parameter int MAX_RD_OUTSTANDING = 4,
    parameter int CNT_W              = $clog2(MAX_RD_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_iob_avalid_i,
    input  logic [ADDR_WIDTH-1:0] s_iob_addr_i,
    input  logic [DATA_WIDTH-1:0] s_iob_wdata_i,
    input  logic [STRB_WIDTH-1:0] s_iob_wstrb_i,
    output logic                  s_iob_ready_o,
    output logic                  s_iob_rvalid_o,
    output logic [DATA_WIDTH-1:0] s_iob_rdata_o,
    output logic                  m_iob_avalid_o,
    output logic [ADDR_WIDTH-1:0] m_iob_addr_o,
    output logic [DATA_WIDTH-1:0] m_iob_wdata_o,
    output logic [STRB_WIDTH-1:0] m_iob_wstrb_o,
    input  logic                  m_iob_ready_i,
    input  logic                  m_iob_rvalid_i,
    input  logic [DATA_WIDTH-1:0] m_iob_rdata_i,
    output logic [CNT_W-1:0]      rd_pending_o,
    output logic                  err_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RD_OUTSTANDING);

    logic                  main_valid;
    logic [ADDR_WIDTH-1:0] main_addr;
    logic [DATA_WIDTH-1:0] main_wdata;
    logic [STRB_WIDTH-1:0] main_wstrb;
    logic                  skid_valid;
    logic [ADDR_WIDTH-1:0] skid_addr;
    logic [DATA_WIDTH-1:0] skid_wdata;
    logic [STRB_WIDTH-1:0] skid_wstrb;
    logic [CNT_W-1:0]      rd_cnt;

    logic main_is_rd;
    logic rd_block;
    logic main_fire;
    logic s_accept;
    logic cnt_inc;
    logic cnt_dec;

    assign main_is_rd     = (main_wstrb == '0);
    assign rd_block       = main_is_rd && (rd_cnt == MAX_CNT);
    assign m_iob_avalid_o = main_valid && !rd_block;
    assign m_iob_addr_o   = main_addr;
    assign m_iob_wdata_o  = main_wdata;
    assign m_iob_wstrb_o  = main_wstrb;
    assign s_iob_ready_o  = !skid_valid;
    assign rd_pending_o   = rd_cnt;

    assign main_fire = m_iob_avalid_o && m_iob_ready_i;
    assign s_accept  = s_iob_avalid_i && s_iob_ready_o;
    assign cnt_inc   = main_fire && main_is_rd;
    assign cnt_dec   = m_iob_rvalid_i && (rd_cnt != '0);

    // Skid is only ever loaded while main is occupied and not draining, so
    // main always holds the oldest request and ordering is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_addr  <= '0;
            main_wdata <= '0;
            main_wstrb <= '0;
            skid_valid <= 1'b0;
            skid_addr  <= '0;
            skid_wdata <= '0;
            skid_wstrb <= '0;
        end else if (main_fire) begin
            if (skid_valid) begin
                main_addr  <= skid_addr;
                main_wdata <= skid_wdata;
                main_wstrb <= skid_wstrb;
                skid_valid <= 1'b0;
            end else if (s_accept) begin
                main_addr  <= s_iob_addr_i;
                main_wdata <= s_iob_wdata_i;
                main_wstrb <= s_iob_wstrb_i;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (s_accept) begin
            if (!main_valid) begin
                main_valid <= 1'b1;
                main_addr  <= s_iob_addr_i;
                main_wdata <= s_iob_wdata_i;
                main_wstrb <= s_iob_wstrb_i;
            end else begin
                skid_valid <= 1'b1;
                skid_addr  <= s_iob_addr_i;
                skid_wdata <= s_iob_wdata_i;
                skid_wstrb <= s_iob_wstrb_i;
            end
        end
    end

    // A response with nothing pending is still forwarded; it only flags err_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt         <= '0;
            err_o          <= 1'b0;
            s_iob_rvalid_o <= 1'b0;
            s_iob_rdata_o  <= '0;
        end else begin
            if (cnt_inc && !cnt_dec) begin
                rd_cnt <= rd_cnt + 1'b1;
            end else if (cnt_dec && !cnt_inc) begin
                rd_cnt <= rd_cnt - 1'b1;
            end
            if (m_iob_rvalid_i && (rd_cnt == '0)) begin
                err_o <= 1'b1;
            end
            s_iob_rvalid_o <= m_iob_rvalid_i;
            if (m_iob_rvalid_i) begin
                s_iob_rdata_o <= m_iob_rdata_i;
            end
        end
    end

endmodule

// File: doc/iob_req_slice.md
Name: iob_req_slice

Overview:
- Registered pipeline stage on the IOb bus. Sits directly downstream of the AXI4-to-IOb bridge's IOb master port and upstream of the IOb interconnect/peripherals.
- Breaks the combinational avalid/ready and rdata timing paths with a two-entry request skid buffer and a registered read-response path.
- Counts outstanding reads and throttles new reads when the limit is reached.

Parameters:
ADDR_WIDTH, 32, request address width in bits
DATA_WIDTH, 32, write/read data width in bits
STRB_WIDTH, DATA_WIDTH/8, write strobe width
MAX_RD_OUTSTANDING, 4, maximum reads forwarded downstream without a response (1..255)
CNT_W, $clog2(MAX_RD_OUTSTANDING+1), width of the outstanding-read counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
s_iob_avalid_i  in  1  upstream request valid
s_iob_addr_i  in  ADDR_WIDTH  upstream request address
s_iob_wdata_i  in  DATA_WIDTH  upstream write data
s_iob_wstrb_i  in  STRB_WIDTH  upstream write strobes; all-zero means read
s_iob_ready_o  out  1  upstream request accept
s_iob_rvalid_o  out  1  upstream read response valid
s_iob_rdata_o  out  DATA_WIDTH  upstream read data
m_iob_avalid_o  out  1  downstream request valid
m_iob_addr_o  out  ADDR_WIDTH  downstream address
m_iob_wdata_o  out  DATA_WIDTH  downstream write data
m_iob_wstrb_o  out  STRB_WIDTH  downstream write strobes
m_iob_ready_i  in  1  downstream request accept
m_iob_rvalid_i  in  1  downstream read response valid
m_iob_rdata_i  in  DATA_WIDTH  downstream read data
rd_pending_o  out  CNT_W  outstanding read count
err_o  out  1  sticky error: rvalid received with zero reads pending

Behaviour:
Protocol rules:
- A request is accepted on a side when avalid & ready are high in the same cycle.
- A request is a read iff wstrb == 0.
- Read responses return in order.
- rvalid has no backpressure.

Reset (rst_n low, asynchronous):
- main/skid entries invalid; counter = 0; err_o = 0.
- s_iob_ready_o = 1; s_iob_rvalid_o = 0; s_iob_rdata_o = 0.
- m_iob_avalid_o = 0; m_iob_addr_o/wdata/wstrb = 0.
- Reset asserted mid-operation discards all queued requests and pending-read state. No response is generated for them.

Request path (main register + skid register):
- s_iob_ready_o = !skid_valid (registered, never depends on m_iob_ready_i combinationally).
- rd_block = main is read & counter == MAX_RD_OUTSTANDING.
- m_iob_avalid_o = main_valid & !rd_block. m_iob_addr/wdata/wstrb are driven from the main register.
- main_fire = m_iob_avalid_o & m_iob_ready_i.
- On s-side accept:
  - if main empty, or main_fire and skid empty → load main;
  - else → load skid.
- On main_fire with skid valid: main <= skid, skid cleared the same cycle. This is simultaneous with any s-side accept, which is legal only if skid was empty beforehand; guaranteed by ready.
- Latency: accept in cycle N → earliest m_iob_avalid_o in N+1.
- Throughput: 1 request/cycle when downstream ready stays high.
- Order is preserved strictly. A blocked read also stalls any following writes; there is no reordering.

Outstanding-read counter:
- +1 on main_fire of a read.
- -1 on m_iob_rvalid_i when counter > 0.
- Simultaneous +1 and -1 → unchanged.
- rd_pending_o = counter.
- m_iob_rvalid_i with counter == 0: counter stays 0, err_o set to 1 until reset. The response is still forwarded.

Response path:
- s_iob_rvalid_o <= m_iob_rvalid_i, one-cycle latency.
- s_iob_rdata_o <= m_iob_rdata_i when m_iob_rvalid_i; otherwise it holds its last value.

Test Plan:
1. Reset, then single write addr=0x10 wdata=0xDEADBEEF wstrb=0xF with m ready=1 → m_iob_avalid_o high exactly 1 cycle, one cycle after accept, carrying same values; rd_pending_o stays 0.
2. Back-to-back 8 writes with m ready held low 3 cycles → s_iob_ready_o drops after 2nd accept; once ready returns, all 8 appear on m side in order with no loss or duplication.
3. 4 reads (MAX=4) with no responses, then 5th read → 5th held (m_iob_avalid_o=0), rd_pending_o=4. One m_iob_rvalid_i with rdata=0x1234 → s_iob_rvalid_o=1, s_iob_rdata_o=0x1234 next cycle, then 5th read issued, count returns to 4.
4. Same cycle: read main_fire and m_iob_rvalid_i with count=2 → count remains 2.
5. m_iob_rvalid_i with count=0 → err_o=1 from next cycle and stays high; s_iob_rvalid_o still pulses.
6. Assert rst_n low while skid full and 3 reads pending → all outputs at reset values immediately; after release, no stale request appears on the m side.
